// File: rtl/instr_mem_loader.sv
// Streams a 16-bit word count plus little-endian words into instruction memory, holding the
// CPU in reset until done. Define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR checksum.
module instr_mem_loader #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned INSTR_MEM_DEPTH = 256,
  parameter int unsigned ADDR_WIDTH      = $clog2(INSTR_MEM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [7:0]            i_byte_data,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic                  o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] o_mem_wr_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wr_data,
  output logic                  o_cpu_reset_n,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam logic [16:0] MaxWords = 17'(INSTR_MEM_DEPTH / 4);

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StWrite,
`ifdef INSTR_LOADER_CHECKSUM_EN
    StCheck,
`endif
    StDone,
    StError
  } state_e;

  state_e                state_q, state_d, end_st;
  logic [15:0]           count_q, count_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  ready_q, wr_en_q, busy_q, done_q, error_q, cpu_rst_n_q;
  logic                  xfer;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  // Outputs are flops, so the handshake uses the registered ready.
  assign xfer = i_byte_valid & ready_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    word_d  = word_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    end_st  = StCheck;
`else
    end_st  = StDone;
`endif
    case (state_q)
      StIdle, StDone, StError: begin
        if (i_start) begin
          state_d = StLenLo;
          count_d = '0;
          idx_d   = '0;
          addr_d  = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StLenLo: begin
        if (xfer) begin
          count_d[7:0] = i_byte_data;
          state_d      = StLenHi;
        end
      end
      StLenHi: begin
        if (xfer) begin
          count_d[15:8] = i_byte_data;
          if (count_d == 16'd0) begin
            state_d = end_st;
          end else if ({1'b0, count_d} > MaxWords) begin
            state_d = StError;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          word_d = {i_byte_data, word_q[DATA_WIDTH-1:8]};
          idx_d  = idx_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ i_byte_data;
`endif
          if (idx_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        addr_d  = addr_q + ADDR_WIDTH'(4);
        count_d = count_q - 16'd1;
        state_d = (count_q == 16'd1) ? end_st : StData;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      StCheck: begin
        if (xfer) begin
          state_d = (i_byte_data == csum_q) ? StDone : StError;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      ready_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      // Output flags are decoded from the next state so they line up with state_q.
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
      ready_q     <= (state_d == StLenLo) || (state_d == StLenHi) || (state_d == StData) ||
                     (state_d == StCheck);
`else
      ready_q     <= (state_d == StLenLo) || (state_d == StLenHi) || (state_d == StData);
`endif
      wr_en_q     <= (state_d == StWrite);
      busy_q      <= (state_d != StIdle) && (state_d != StDone) && (state_d != StError);
      done_q      <= (state_d == StDone);
      error_q     <= (state_d == StError);
      cpu_rst_n_q <= (state_d == StDone);
    end
  end

  assign o_byte_ready  = ready_q;
  assign o_mem_wr_en   = wr_en_q;
  assign o_mem_wr_addr = addr_q;
  assign o_mem_wr_data = word_q;
  assign o_cpu_reset_n = cpu_rst_n_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized scoreboard bench for instr_mem_loader; expected writes are queued by the stimulus
// and popped by an independent write monitor.
module tb_instr_mem_loader;

  localparam int unsigned Depth    = 256;
  localparam int unsigned MaxWords = Depth / 4;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_byte_valid;
  logic [7:0]  i_byte_data;
  logic        o_byte_ready, o_mem_wr_en, o_cpu_reset_n, o_busy, o_done, o_error;
  logic [7:0]  o_mem_wr_addr;
  logic [31:0] o_mem_wr_data;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  instr_mem_loader #(
    .DATA_WIDTH     (32),
    .INSTR_MEM_DEPTH(Depth)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_byte_data  (i_byte_data),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_mem_wr_en  (o_mem_wr_en),
    .o_mem_wr_addr(o_mem_wr_addr),
    .o_mem_wr_data(o_mem_wr_data),
    .o_cpu_reset_n(o_cpu_reset_n),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (o_mem_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                 o_mem_wr_addr, o_mem_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", o_mem_wr_addr, e.addr);
        chk("wr_data", o_mem_wr_data, e.data);
      end
    end
  end

  // Offer a byte, optionally after random idle cycles; returns just after its transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        i_byte_valid = 1'b0;
        i_byte_data  = 8'($urandom);
        tick();
      end
    end
    i_byte_data  = b;
    i_byte_valid = 1'b1;
    while (o_byte_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      $display("FAIL ready_timeout: got ready=%b after %0d cycles, required 1", o_byte_ready, n);
    end
    tick();
    i_byte_valid = 1'b0;
  endtask

  // Runs one load of words[0..count-1]; counts above MaxWords must be rejected.
  task automatic do_load(input int unsigned count, input bit gaps, input bit noise,
                         input bit bad_csum);
    logic [7:0]  cs = 8'h00;
    logic [31:0] w;
    logic [15:0] c16;
    c16 = 16'(count);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1);
    chk("done_cleared", o_done, 0);
    chk("error_cleared", o_error, 0);
    chk("cpu_held_after_start", o_cpu_reset_n, 0);
    send_byte(c16[7:0], gaps);
    send_byte(c16[15:8], gaps);
    if (count > MaxWords) begin
      chk("oversize_error", o_error, 1);
      chk("oversize_ready", o_byte_ready, 0);
      chk("oversize_cpu_rst", o_cpu_reset_n, 0);
      chk("oversize_busy", o_busy, 0);
      return;
    end
    for (int i = 0; i < int'(count); i++) begin
      w = words[i];
      exp_q.push_back({8'(4 * i), w});
      if (noise && i > 0) begin
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
      end
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8], gaps);
        cs = cs ^ w[8*b +: 8];
      end
      chk("wr_strobe_after_4th", o_mem_wr_en, 1);
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (cs ^ 8'h5A) : cs, gaps);
`else
    if (count > 0) tick();
`endif
    if (bad_csum) begin
      chk("csum_error", o_error, 1);
      chk("csum_cpu_rst", o_cpu_reset_n, 0);
    end else begin
      chk("load_done", o_done, 1);
      chk("load_cpu_rst_n", o_cpu_reset_n, 1);
      chk("load_busy", o_busy, 0);
      chk("load_ready", o_byte_ready, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset      = 1'b1;
    i_start      = 1'b0;
    i_byte_valid = 1'b0;
    i_byte_data  = 8'h00;
    tick();
    tick();
    chk("rst_ready", o_byte_ready, 0);
    chk("rst_wr_en", o_mem_wr_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_addr", o_mem_wr_addr, 0);
    chk("rst_data", o_mem_wr_data, 0);
    chk("rst_cpu_rst_n", o_cpu_reset_n, 0);
    i_reset = 1'b0;
    tick();

    // Reset after two data bytes aborts without a write.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    chk("midload_busy", o_busy, 1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("abort_ready", o_byte_ready, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_data", o_mem_wr_data, 0);
    chk("abort_wr_en", o_mem_wr_en, 0);
    chk("abort_cpu_rst_n", o_cpu_reset_n, 0);
    tick();
    chk("abort_idle_ready", o_byte_ready, 0);

    words = '{32'h0050_0513, 32'h01EE_0213};
    do_load(2, 1'b0, 1'b0, 1'b0);
    do_load(2, 1'b1, 1'b0, 1'b0);
    do_load(0, 1'b0, 1'b0, 1'b0);

    words = {};
    for (int i = 0; i < int'(MaxWords); i++) words.push_back($urandom);
    do_load(MaxWords, 1'(($urandom & 1)), 1'b0, 1'b0);

    do_load(MaxWords + 1, 1'b0, 1'b0, 1'b0);
    i_byte_valid = 1'b1;
    i_byte_data  = 8'hA5;
    repeat (3) begin
      tick();
      chk("error_holds_ready", o_byte_ready, 0);
    end
    i_byte_valid = 1'b0;

    words = '{32'h0050_0513, 32'h01EE_0213};
    do_load(2, 1'b0, 1'b0, 1'b0);
    words = '{32'hDEAD_BEEF};
    do_load(1, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      int unsigned cnt;
      cnt   = $urandom_range(1, 6);
      words = {};
      for (int i = 0; i < int'(cnt); i++) words.push_back($urandom);
      do_load(cnt, 1'($urandom & 1), 1'($urandom & 1), 1'b0);
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    words = '{32'h0050_0513, 32'h01EE_0213};
    do_load(2, 1'b0, 1'b0, 1'b1);
`endif

    repeat (5) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
